cpu_int_seq: RTL and testbench
==============================

Name: cpu_int_seq

Overview:
- 6502 interrupt/reset sequencer for the NES CPU core.
- Consumes the processor status byte produced by the ALU/flag path and the current PC/SP.
- Performs the 7-cycle RESET/NMI/IRQ/BRK stack-push and vector-fetch sequence.
- Hands the vector back to the control unit as a PC load.

Parameters:
- VEC_NMI, 16'hFFFA, NMI vector low-byte address
- VEC_RST, 16'hFFFC, RESET vector low-byte address
- VEC_IRQ, 16'hFFFE, IRQ/BRK vector low-byte address

Ports:
- clk  in  1  system clock; all state changes on rising edge
- reset  in  1  asynchronous, active-high reset
- rdy  in  1  bus ready; 0 freezes sequencer state and all registers
- instr_boundary  in  1  control unit at opcode-fetch boundary; requests are sampled only here
- brk_req  in  1  decoder has a BRK opcode (valid with instr_boundary)
- nmi_n  in  1  NMI line, already synchronous to clk
- irq_n  in  1  IRQ line, level, synchronous
- status_in  in  8  current P register (N V 1 B D I Z C, bit7..0)
- pc_in  in  16  PC to push (decoder supplies PC+2 for BRK)
- sp_in  in  8  current stack pointer
- data_in  in  8  read data, valid at the edge ending a read cycle
- busy  out  1  sequence in progress; control unit must stall
- addr  out  16  bus address
- data_out  out  8  write data
- we  out  1  write strobe
- sp_out  out  8  decremented stack pointer
- sp_load  out  1  load sp_out into SP
- pc_out  out  16  vector target
- pc_load  out  1  one-cycle PC load pulse
- set_i  out  1  one-cycle pulse: control sets P.I=1

Behaviour:
- States: IDLE, DUMMY, PCH, PCL, PUSHP, VLO, VHI, DONE.
- reset asserted: state=DUMMY with src=RESET; nmi_pending=0.
- Outputs during reset: busy=1, we=0, sp_load=0, pc_load=0, set_i=0, addr=16'h0000, data_out=0, pc_out=0, sp_out=sp_in.
- Reset is asynchronous mid-sequence: any state is abandoned immediately.
- NMI edge detect:
  - nmi_pending sets on nmi_n 1->0 (registered previous value; reset value 1).
  - Clears when the NMI vector is fetched in VLO.
  - An edge arriving in that same VLO cycle re-arms it.
- IDLE accept, only while instr_boundary=1, rdy=1. Priority NMI(pending) > IRQ (irq_n=0 and status_in[2]=0) > BRK (brk_req). Winner latched to src; next state DUMMY. busy is combinational: 1 in DUMMY..DONE and in the accept cycle.
- DUMMY: addr=pc_in read, no write. Latch pc_in, status_in, sp_in into internal regs.
- PCH, PCL, PUSHP: addr={8'h01,sp}.
  - data_out = PC[15:8], PC[7:0], P respectively.
  - we=1 except src=RESET (we=0, reads only).
  - sp decrements by 1 each (8-bit wrap: 8'h00 -> 8'hFF); sp_load pulses each cycle with new value.
- Pushed P = status with bit5=1; bit4 (B)=1 only for src=BRK, else 0.
- VLO: addr = vector low.
  - Vector: RESET -> VEC_RST. NMI -> VEC_NMI. IRQ/BRK -> VEC_NMI if nmi_pending (hijack, clears pending; pushed B unchanged), else VEC_IRQ.
  - Capture data_in as lo. set_i pulses here.
- VHI: addr = vector low + 1; capture data_in as hi.
- DONE: pc_out={hi,lo}, pc_load=1 for one cycle, busy=1; next IDLE.
- Fixed latency: accept edge -> pc_load is 7 clocks with rdy held 1.
- rdy=0 in any state: hold state, we forced 0, sp_load/pc_load/set_i forced 0; the cycle repeats when rdy returns.
- instr_boundary=0 in IDLE: no accept, even if requests are pending.
- Simultaneous NMI edge and accept in same cycle: pending is not yet set, so IRQ/BRK wins and NMI is taken via hijack at VLO.
- After reset release: reset sequence runs without instr_boundary.

Test Plan:
- Reset release, sp_in=8'h00, mem[FFFC]=34, mem[FFFD]=12:
  - no we during sequence; sp_out 8'hFF, 8'hFE, 8'hFD.
  - pc_load with pc_out=16'h1234 at 7th clock.
- IRQ, irq_n=0, status_in=8'h00, pc_in=16'hC123, sp=8'hFF:
  - writes 01FF=C1, 01FE=23, 01FD=8'h20; addr FFFE/FFFF read; set_i pulse.
  - Same stimulus with status_in[2]=1 -> no accept, busy stays 0.
- BRK, pc_in=16'h8002, status_in=8'h81: pushed P=8'hB1, vector FFFE.
  - nmi_n falls during PCL -> addr FFFA at VLO, pushed P still 8'hB1, nmi_pending cleared.
- NMI, one falling edge with irq_n=0 simultaneously pending: NMI serviced first (FFFA); IRQ accepted at following boundary.
  - A second falling edge during VHI triggers a second NMI afterward.
- rdy=0 for 3 cycles during PUSHP: we=0 and state held for those cycles, single write of P afterward.
  - Total latency 10 clocks.
- reset asserted during VLO of an IRQ: outputs go to reset values immediately.
  - Full reset sequence follows and fetches FFFC.

Source files
------------

// File: rtl/cpu_int_seq_if.sv
`default_nettype none
// ============================================================================
// Module      : cpu_int_seq_if
// Description : Bus/handshake bundle between the NES CPU control unit
//               (master) and the interrupt/reset sequencer (slave).
// Revision    : 1.0 - initial release
// ============================================================================
interface cpu_int_seq_if;
    // Control unit -> sequencer
    logic        rdy;
    logic        instr_boundary;
    logic        brk_req;
    logic        nmi_n;
    logic        irq_n;
    logic [7:0]  status_in;
    logic [15:0] pc_in;
    logic [7:0]  sp_in;
    logic [7:0]  data_in;

    // Sequencer -> control unit / bus
    logic        busy;
    logic [15:0] addr;
    logic [7:0]  data_out;
    logic        we;
    logic [7:0]  sp_out;
    logic        sp_load;
    logic [15:0] pc_out;
    logic        pc_load;
    logic        set_i;

    modport master (
        output rdy, instr_boundary, brk_req, nmi_n, irq_n,
               status_in, pc_in, sp_in, data_in,
        input  busy, addr, data_out, we, sp_out, sp_load,
               pc_out, pc_load, set_i
    );

    modport slave (
        input  rdy, instr_boundary, brk_req, nmi_n, irq_n,
               status_in, pc_in, sp_in, data_in,
        output busy, addr, data_out, we, sp_out, sp_load,
               pc_out, pc_load, set_i
    );
endinterface
`default_nettype wire

// File: rtl/cpu_int_seq.sv
`default_nettype none
// ============================================================================
// Module      : cpu_int_seq
// Description : 6502 RESET/NMI/IRQ/BRK sequencer. Runs the 7-cycle
//               push-PC/push-P/fetch-vector sequence and hands the vector
//               back to the control unit as a one-cycle PC load.
// Revision    : 1.0 - initial release
// ============================================================================
module cpu_int_seq #(
    parameter logic [15:0] VEC_NMI = 16'hFFFA,
    parameter logic [15:0] VEC_RST = 16'hFFFC,
    parameter logic [15:0] VEC_IRQ = 16'hFFFE
) (
    input  wire logic    clk,
    input  wire logic    reset,
    cpu_int_seq_if.slave bus
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_DUMMY = 3'd1,
        S_PCH   = 3'd2,
        S_PCL   = 3'd3,
        S_PUSHP = 3'd4,
        S_VLO   = 3'd5,
        S_VHI   = 3'd6,
        S_DONE  = 3'd7
    } state_t;

    typedef enum logic [1:0] {
        SRC_RESET = 2'd0,
        SRC_NMI   = 2'd1,
        SRC_IRQ   = 2'd2,
        SRC_BRK   = 2'd3
    } src_t;

    state_t      r_state;
    state_t      w_state_nxt;
    src_t        r_src;
    src_t        w_src_sel;

    logic        r_nmi_prev;
    logic        r_nmi_pending;

    logic [15:0] r_pc;
    logic [7:0]  r_p;
    logic [7:0]  r_sp;
    logic [7:0]  r_lo;
    logic [7:0]  r_hi;
    logic [15:0] r_vec;

    logic        w_nmi_edge;
    logic        w_irq_req;
    logic        w_any_req;
    logic        w_accept;
    logic        w_nmi_take;
    logic [15:0] w_vec;
    logic [7:0]  w_push_p;
    logic [7:0]  w_sp_dec;
    logic        w_push_we;

    // Request decode, priority arbitration and vector selection
    always_comb begin
        w_nmi_edge = r_nmi_prev & ~bus.nmi_n;
        w_irq_req  = ~bus.irq_n & ~bus.status_in[2];
        w_any_req  = r_nmi_pending | w_irq_req | bus.brk_req;
        w_accept   = (r_state == S_IDLE) & bus.instr_boundary & bus.rdy & w_any_req;

        // An NMI already pending beats IRQ; an edge in the accept cycle is
        // not pending yet and gets picked up by the hijack at VLO instead.
        if (r_nmi_pending) begin
            w_src_sel = SRC_NMI;
        end else if (w_irq_req) begin
            w_src_sel = SRC_IRQ;
        end else begin
            w_src_sel = SRC_BRK;
        end

        // IRQ/BRK get redirected to the NMI vector if an NMI arrived
        // mid-sequence; the pushed B bit keeps reflecting the original source.
        case (r_src)
            SRC_RESET: w_vec = VEC_RST;
            SRC_NMI:   w_vec = VEC_NMI;
            default:   w_vec = r_nmi_pending ? VEC_NMI : VEC_IRQ;
        endcase

        w_nmi_take = (r_state == S_VLO) & bus.rdy & (r_src != SRC_RESET) &
                     ((r_src == SRC_NMI) | r_nmi_pending);

        w_push_p  = {r_p[7:6], 1'b1, (r_src == SRC_BRK), r_p[3:0]};
        w_sp_dec  = r_sp - 8'd1;
        w_push_we = (r_src != SRC_RESET);
    end

    // State register; reset forces the reset sequence to start at DUMMY
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_DUMMY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and bus outputs; rdy=0 stalls and masks all strobes
    always_comb begin
        w_state_nxt  = r_state;
        bus.busy     = (r_state != S_IDLE) | w_accept;
        bus.addr     = 16'h0000;
        bus.data_out = 8'h00;
        bus.we       = 1'b0;
        bus.sp_out   = bus.sp_in;
        bus.sp_load  = 1'b0;
        bus.pc_out   = 16'h0000;
        bus.pc_load  = 1'b0;
        bus.set_i    = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = S_DUMMY;
                end
            end
            S_DUMMY: begin
                bus.addr    = bus.pc_in;
                w_state_nxt = S_PCH;
            end
            S_PCH: begin
                bus.addr     = {8'h01, r_sp};
                bus.data_out = r_pc[15:8];
                bus.we       = w_push_we;
                bus.sp_out   = w_sp_dec;
                bus.sp_load  = 1'b1;
                w_state_nxt  = S_PCL;
            end
            S_PCL: begin
                bus.addr     = {8'h01, r_sp};
                bus.data_out = r_pc[7:0];
                bus.we       = w_push_we;
                bus.sp_out   = w_sp_dec;
                bus.sp_load  = 1'b1;
                w_state_nxt  = S_PUSHP;
            end
            S_PUSHP: begin
                bus.addr     = {8'h01, r_sp};
                bus.data_out = w_push_p;
                bus.we       = w_push_we;
                bus.sp_out   = w_sp_dec;
                bus.sp_load  = 1'b1;
                w_state_nxt  = S_VLO;
            end
            S_VLO: begin
                bus.addr    = w_vec;
                bus.set_i   = 1'b1;
                w_state_nxt = S_VHI;
            end
            S_VHI: begin
                bus.addr    = r_vec + 16'd1;
                w_state_nxt = S_DONE;
            end
            S_DONE: begin
                bus.pc_out  = {r_hi, r_lo};
                bus.pc_load = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        if (!bus.rdy) begin
            w_state_nxt = r_state;
            bus.we      = 1'b0;
            bus.sp_load = 1'b0;
            bus.pc_load = 1'b0;
            bus.set_i   = 1'b0;
        end

        // Reset is asynchronous, so the bus must go quiet the moment it rises
        if (reset) begin
            bus.busy     = 1'b1;
            bus.addr     = 16'h0000;
            bus.data_out = 8'h00;
            bus.we       = 1'b0;
            bus.sp_out   = bus.sp_in;
            bus.sp_load  = 1'b0;
            bus.pc_out   = 16'h0000;
            bus.pc_load  = 1'b0;
            bus.set_i    = 1'b0;
        end
    end

    // NMI falling-edge detector with pending flag; clear and re-arm can coincide
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_nmi_prev    <= 1'b1;
            r_nmi_pending <= 1'b0;
        end else if (bus.rdy) begin
            r_nmi_prev    <= bus.nmi_n;
            r_nmi_pending <= w_nmi_edge | (r_nmi_pending & ~w_nmi_take);
        end
    end

    // Sequence datapath: source latch, snapshot of PC/P/SP, vector capture
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_src <= SRC_RESET;
            r_pc  <= 16'h0000;
            r_p   <= 8'h00;
            r_sp  <= 8'h00;
            r_lo  <= 8'h00;
            r_hi  <= 8'h00;
            r_vec <= 16'h0000;
        end else if (bus.rdy) begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_src <= w_src_sel;
                    end
                end
                S_DUMMY: begin
                    r_pc <= bus.pc_in;
                    r_p  <= bus.status_in;
                    r_sp <= bus.sp_in;
                end
                S_PCH, S_PCL, S_PUSHP: begin
                    r_sp <= w_sp_dec;
                end
                S_VLO: begin
                    r_lo  <= bus.data_in;
                    r_vec <= w_vec;
                end
                S_VHI: begin
                    r_hi <= bus.data_in;
                end
                default: begin
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_cpu_int_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_cpu_int_seq
// Description : Scoreboard bench for cpu_int_seq. Expected bus events
//               (writes, SP loads, set_i with vector address, PC loads) are
//               queued when a sequence is launched and popped as they appear.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cpu_int_seq;

    logic clk = 1'b0;
    logic reset;

    cpu_int_seq_if bif ();

    cpu_int_seq #(
        .VEC_NMI (16'hFFFA),
        .VEC_RST (16'hFFFC),
        .VEC_IRQ (16'hFFFE)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bif)
    );

    always #5 clk = ~clk;

    logic [7:0] mem [0:65535];
    assign bif.data_in = mem[bif.addr];

    localparam logic [3:0] K_WR   = 4'd0;
    localparam logic [3:0] K_SP   = 4'd1;
    localparam logic [3:0] K_SETI = 4'd2;
    localparam logic [3:0] K_PCLD = 4'd3;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [27:0] sb_q [$];
    int          lat;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic void push_ev(input logic [3:0] k, input logic [15:0] a, input logic [7:0] d);
        sb_q.push_back({k, a, d});
    endfunction

    // Full interrupt frame: three pushes, vector fetch, PC load
    function automatic void push_frame(input logic [15:0] pc, input logic [7:0] p,
                                       input logic [7:0] sp, input logic [15:0] vec,
                                       input logic [15:0] target);
        logic [7:0] s;
        s = sp;
        push_ev(K_WR, {8'h01, s}, pc[15:8]);  s = s - 8'd1; push_ev(K_SP, 16'h0, s);
        push_ev(K_WR, {8'h01, s}, pc[7:0]);   s = s - 8'd1; push_ev(K_SP, 16'h0, s);
        push_ev(K_WR, {8'h01, s}, p);         s = s - 8'd1; push_ev(K_SP, 16'h0, s);
        push_ev(K_SETI, vec, 8'h00);
        push_ev(K_PCLD, target, 8'h00);
    endfunction

    // Reset frame: SP still walks down, but nothing is written
    function automatic void push_reset(input logic [7:0] sp);
        logic [7:0] s;
        s = sp;
        for (int k = 0; k < 3; k++) begin
            s = s - 8'd1;
            push_ev(K_SP, 16'h0, s);
        end
        push_ev(K_SETI, 16'hFFFC, 8'h00);
        push_ev(K_PCLD, 16'h1234, 8'h00);
    endfunction

    task automatic sb_cmp(input logic [3:0] k, input logic [15:0] a, input logic [7:0] d, input string tag);
        logic [27:0] ev;
        logic [27:0] ex;
        ev = {k, a, d};
        if (sb_q.size() == 0) begin
            check({"unexpected_", tag}, 64'(ev), 64'h0FFF_FFFF);
        end else begin
            ex = sb_q.pop_front();
            check(tag, 64'(ev), 64'(ex));
        end
    endtask

    // Bus monitor, sampled mid-cycle after stimulus has settled
    always @(negedge clk) begin
        #2;
        if (bif.we)      sb_cmp(K_WR,   bif.addr,   bif.data_out, "write");
        if (bif.sp_load) sb_cmp(K_SP,   16'h0,      bif.sp_out,   "sp_load");
        if (bif.set_i)   sb_cmp(K_SETI, bif.addr,   8'h00,        "set_i_vec");
        if (bif.pc_load) sb_cmp(K_PCLD, bif.pc_out, 8'h00,        "pc_load");
    end

    function automatic logic [63:0] out_pack();
        return 64'({bif.busy, bif.we, bif.sp_load, bif.pc_load, bif.set_i,
                    bif.addr, bif.data_out, bif.pc_out, bif.sp_out});
    endfunction

    function automatic logic [63:0] rst_pack(input logic [7:0] sp);
        return 64'({5'b10000, 16'h0000, 8'h00, 16'h0000, sp});
    endfunction

    // Launch from an IDLE cycle with instr_boundary already set; i counts
    // mid-cycle samples after the accept edge (1=DUMMY ... 7=DONE).
    task automatic run_seq(input int nmi_fall, input int nmi_rise, input int stall_at,
                           input int rst_at, output int lat_o);
        int i;
        bit found;
        i     = 0;
        found = 1'b0;
        lat_o = 0;
        @(posedge clk);
        while (!found && i < 40) begin
            @(negedge clk);
            i++;
            if (i == 1) bif.instr_boundary = 1'b0;
            if (i == nmi_fall) bif.nmi_n = 1'b0;
            if (i == nmi_rise) bif.nmi_n = 1'b1;
            if (stall_at > 0 && i == stall_at) bif.rdy = 1'b0;
            if (stall_at > 0 && i == stall_at + 3) bif.rdy = 1'b1;
            if (rst_at > 0 && i == rst_at) reset = 1'b1;
            if (rst_at > 0 && i == rst_at + 2) reset = 1'b0;
            #2;
            if (stall_at > 0 && i >= stall_at && i < stall_at + 3)
                check("stall_we_sp", 64'({bif.we, bif.sp_load}), 64'd0);
            if (rst_at > 0 && i == rst_at)
                check("mid_reset_outputs", out_pack(), rst_pack(bif.sp_in));
            if (bif.pc_load) begin
                found = 1'b1;
                lat_o = i;
            end
        end
        check("pc_load_seen", 64'(found), 64'd1);
        @(negedge clk);
        #2;
    endtask

    task automatic expect_idle(input string tag, input int cycles);
        for (int k = 0; k < cycles; k++) begin
            @(negedge clk);
            #2;
            check(tag, 64'(bif.busy), 64'd0);
        end
    endtask

    initial begin
        for (int a = 0; a < 65536; a++) mem[a] = 8'h00;
        mem[16'hFFFA] = 8'h00; mem[16'hFFFB] = 8'h90;
        mem[16'hFFFC] = 8'h34; mem[16'hFFFD] = 8'h12;
        mem[16'hFFFE] = 8'h00; mem[16'hFFFF] = 8'hA0;

        reset              = 1'b1;
        bif.rdy            = 1'b1;
        bif.instr_boundary = 1'b0;
        bif.brk_req        = 1'b0;
        bif.nmi_n          = 1'b1;
        bif.irq_n          = 1'b1;
        bif.status_in      = 8'h00;
        bif.pc_in          = 16'h0000;
        bif.sp_in          = 8'h5A;

        // Reset outputs and the reset sequence (SP wraps 00 -> FF)
        repeat (2) @(negedge clk);
        #2;
        check("reset_outputs", out_pack(), rst_pack(8'h5A));
        bif.sp_in = 8'h00;
        push_reset(8'h00);
        @(negedge clk);
        reset = 1'b0;
        begin
            int n;
            n = 0;
            #2;
            while (bif.busy && n < 30) begin
                @(negedge clk);
                #2;
                n++;
            end
            check("reset_seq_idle", 64'(bif.busy), 64'd0);
        end
        check("reset_drain", 64'(sb_q.size()), 64'd0);

        // IRQ
        bif.status_in = 8'h00; bif.pc_in = 16'hC123; bif.sp_in = 8'hFF;
        bif.irq_n = 1'b0; bif.instr_boundary = 1'b1;
        push_frame(16'hC123, 8'h20, 8'hFF, 16'hFFFE, 16'hA000);
        run_seq(0, 0, 0, 0, lat);
        check("irq_latency", 64'(lat), 64'd7);
        check("irq_drain", 64'(sb_q.size()), 64'd0);

        // IRQ masked by P.I, and no accept off the instruction boundary
        bif.status_in = 8'h04; bif.instr_boundary = 1'b1;
        expect_idle("irq_masked_busy", 3);
        bif.status_in = 8'h00; bif.instr_boundary = 1'b0;
        expect_idle("no_boundary_busy", 2);
        bif.irq_n = 1'b1;

        // BRK
        bif.pc_in = 16'h8002; bif.status_in = 8'h81; bif.sp_in = 8'hFD;
        bif.brk_req = 1'b1; bif.instr_boundary = 1'b1;
        push_frame(16'h8002, 8'hB1, 8'hFD, 16'hFFFE, 16'hA000);
        run_seq(0, 0, 0, 0, lat);
        check("brk_latency", 64'(lat), 64'd7);
        check("brk_drain", 64'(sb_q.size()), 64'd0);

        // BRK hijacked by an NMI edge during PCL; B stays set in pushed P
        bif.sp_in = 8'hFA; bif.instr_boundary = 1'b1;
        push_frame(16'h8002, 8'hB1, 8'hFA, 16'hFFFA, 16'h9000);
        run_seq(3, 0, 0, 0, lat);
        bif.brk_req = 1'b0;
        check("hijack_drain", 64'(sb_q.size()), 64'd0);
        bif.instr_boundary = 1'b1;
        expect_idle("nmi_pending_cleared", 2);
        bif.instr_boundary = 1'b0;
        bif.nmi_n = 1'b1;
        @(negedge clk);
        #2;

        // NMI pending alongside IRQ; second NMI edge during VHI
        bif.status_in = 8'h00; bif.irq_n = 1'b0; bif.nmi_n = 1'b0;
        @(negedge clk);
        #2;
        bif.pc_in = 16'h4000; bif.sp_in = 8'hF7; bif.instr_boundary = 1'b1;
        push_frame(16'h4000, 8'h20, 8'hF7, 16'hFFFA, 16'h9000);
        run_seq(6, 2, 0, 0, lat);
        check("nmi_latency", 64'(lat), 64'd7);
        bif.sp_in = 8'hF4; bif.instr_boundary = 1'b1;
        push_frame(16'h4000, 8'h20, 8'hF4, 16'hFFFA, 16'h9000);
        run_seq(0, 0, 0, 0, lat);
        bif.sp_in = 8'hF1; bif.instr_boundary = 1'b1;
        push_frame(16'h4000, 8'h20, 8'hF1, 16'hFFFE, 16'hA000);
        run_seq(0, 0, 0, 0, lat);
        check("nmi_irq_drain", 64'(sb_q.size()), 64'd0);
        bif.irq_n = 1'b1; bif.nmi_n = 1'b1;

        // rdy stall for three cycles during PUSHP
        bif.pc_in = 16'hC123; bif.sp_in = 8'hFF; bif.status_in = 8'h00;
        bif.irq_n = 1'b0; bif.instr_boundary = 1'b1;
        push_frame(16'hC123, 8'h20, 8'hFF, 16'hFFFE, 16'hA000);
        run_seq(0, 0, 4, 0, lat);
        check("stall_latency", 64'(lat), 64'd10);
        check("stall_drain", 64'(sb_q.size()), 64'd0);

        // Reset in VLO of an IRQ: partial frame, then full reset sequence
        bif.instr_boundary = 1'b1;
        push_ev(K_WR, 16'h01FF, 8'hC1); push_ev(K_SP, 16'h0, 8'hFE);
        push_ev(K_WR, 16'h01FE, 8'h23); push_ev(K_SP, 16'h0, 8'hFD);
        push_ev(K_WR, 16'h01FD, 8'h20); push_ev(K_SP, 16'h0, 8'hFC);
        push_reset(8'hFF);
        run_seq(0, 0, 0, 5, lat);
        bif.irq_n = 1'b1;
        check("mid_reset_drain", 64'(sb_q.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
